// File: rtl/rr_grant_encoder.sv
// rr_grant_encoder: round-robin arbiter over NUM_CLIENTS request lines.
// It presents a registered one-hot grant and its binary index through a
// valid/ready handshake. Back-to-back grants are issued without a bubble
// while the consumer keeps gnt_ready high. A presented grant stays stable
// until it is accepted.
module rr_grant_encoder #(
    parameter int NUM_CLIENTS = 16,
    localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_CLIENTS-1:0] req,
    output logic                   gnt_valid,
    input  logic                   gnt_ready,
    output logic [NUM_CLIENTS-1:0] gnt_onehot,
    output logic [IDX_W-1:0]       gnt_idx,
    output logic                   busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t state;

    // Index of the most recently accepted client; the search starts just above it.
    logic [IDX_W-1:0] last_idx;

    // Combinational arbitration signals
    logic [IDX_W-1:0]       ptr;
    logic [NUM_CLIENTS-1:0] above_ptr;
    logic [NUM_CLIENTS-1:0] hi;
    logic [NUM_CLIENTS-1:0] pick_src;
    logic [NUM_CLIENTS-1:0] win_onehot;
    logic [IDX_W-1:0]       win_idx;
    logic                   any_req;

    // Builds the constant mask of client positions whose index has bit b set.
    function automatic logic [NUM_CLIENTS-1:0] idx_mask(input int b);
        logic [NUM_CLIENTS-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            m[i] = ((i >> b) & 1) != 0;
        end
        return m;
    endfunction

    // In GRANT the pointer used is the index being presented. It becomes the
    // new last_idx on acceptance, so the same-cycle re-arbitration already
    // sees the updated pointer. In IDLE the stored pointer is used.
    assign ptr = (state == GRANT) ? gnt_idx : last_idx;

    // Thermometer of positions strictly above the pointer. This is a plain
    // compare per bit, so no shifter is needed for non-power-of-two sizes.
    for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_above
        assign above_ptr[i] = (32'(i) > 32'(ptr));
    end

    assign any_req  = |req;
    assign hi       = req & above_ptr;
    assign pick_src = (|hi) ? hi : req;

    // The lowest set bit is isolated with the two's-complement trick x & -x.
    // The result is one-hot, or all-zero when nobody requests.
    assign win_onehot = pick_src & ((~pick_src) + NUM_CLIENTS'(1));

    // Each index bit is the OR of the grant bits whose position has that bit set.
    // There is no priority loop on this path. Unused codes can never appear
    // because win_onehot only has bits below NUM_CLIENTS.
    for (genvar b = 0; b < IDX_W; b++) begin : g_idx
        localparam logic [NUM_CLIENTS-1:0] MASK = idx_mask(b);
        assign win_idx[b] = |(win_onehot & MASK);
    end

    // Grant state machine with registered outputs and the round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            gnt_valid  <= 1'b0;
            gnt_onehot <= '0;
            gnt_idx    <= '0;
            busy       <= 1'b0;
            last_idx   <= IDX_W'(NUM_CLIENTS - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state      <= GRANT;
                        gnt_valid  <= 1'b1;
                        busy       <= 1'b1;
                        gnt_onehot <= win_onehot;
                        gnt_idx    <= win_idx;
                    end
                end
                GRANT: begin
                    if (gnt_ready) begin
                        last_idx <= gnt_idx;
                        if (any_req) begin
                            gnt_onehot <= win_onehot;
                            gnt_idx    <= win_idx;
                        end else begin
                            state      <= IDLE;
                            gnt_valid  <= 1'b0;
                            busy       <= 1'b0;
                            gnt_onehot <= '0;
                            gnt_idx    <= '0;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    gnt_valid  <= 1'b0;
                    busy       <= 1'b0;
                    gnt_onehot <= '0;
                    gnt_idx    <= '0;
                end
            endcase
        end
    end

    // Structural invariants of the grant outputs.
    a_onehot_iff_valid : assert property (@(posedge clk) disable iff (rst)
        (gnt_valid ? $onehot(gnt_onehot) : (gnt_onehot == '0)));

    a_idx_matches : assert property (@(posedge clk) disable iff (rst)
        gnt_valid |-> (32'(gnt_idx) < NUM_CLIENTS) && gnt_onehot[gnt_idx]);

    a_stable_under_backpressure : assert property (@(posedge clk) disable iff (rst)
        (gnt_valid && !gnt_ready) |=> (gnt_valid && $stable(gnt_onehot) && $stable(gnt_idx)));

endmodule

// File: tb/tb_rr_grant_encoder.sv
// tb_rr_grant_encoder: checks a 16-client and a 5-client arbiter against a
// round-robin reference model. The model scans clients circularly, starting
// just after the last accepted one. Directed scenarios run first, followed
// by randomized requests and backpressure.
module tb_rr_grant_encoder;

    logic        clk;
    logic        rst;

    logic [15:0] req16;
    logic        ready16;
    logic        valid16;
    logic [15:0] onehot16;
    logic [3:0]  idx16;
    logic        busy16;

    logic [4:0]  req5;
    logic        ready5;
    logic        valid5;
    logic [4:0]  onehot5;
    logic [2:0]  idx5;
    logic        busy5;

    int checkCount;
    int passCount;
    int failCount;

    // Reference model state per design: [0] = 16 clients, [1] = 5 clients
    int  mN     [2];
    bit  mValid [2];
    int  mIdx   [2];
    int  mLast  [2];

    rr_grant_encoder #(.NUM_CLIENTS(16)) dut16 (
        .clk        (clk),
        .rst        (rst),
        .req        (req16),
        .gnt_valid  (valid16),
        .gnt_ready  (ready16),
        .gnt_onehot (onehot16),
        .gnt_idx    (idx16),
        .busy       (busy16)
    );

    rr_grant_encoder #(.NUM_CLIENTS(5)) dut5 (
        .clk        (clk),
        .rst        (rst),
        .req        (req5),
        .gnt_valid  (valid5),
        .gnt_ready  (ready5),
        .gnt_onehot (onehot5),
        .gnt_idx    (idx5),
        .busy       (busy5)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts every comparison and reports any mismatch
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, observed, expected, $time);
        end else begin
            passCount++;
        end
    endtask

    // First requesting client found scanning circularly after position p
    function automatic int pickNext(input int n, input logic [15:0] r, input int p);
        for (int k = 1; k <= n; k++) begin
            int c;
            c = (p + k) % n;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            mValid[d] = 1'b0;
            mIdx[d]   = 0;
            mLast[d]  = mN[d] - 1;
        end
    endtask

    // Advances one design's model by one clock, given the inputs seen at that edge
    task automatic modelStep(input int d, input logic [15:0] r, input logic rdy);
        if (!mValid[d]) begin
            if (r != 16'h0) begin
                mIdx[d]   = pickNext(mN[d], r, mLast[d]);
                mValid[d] = 1'b1;
            end
        end else if (rdy) begin
            mLast[d] = mIdx[d];
            if (r != 16'h0) begin
                mIdx[d] = pickNext(mN[d], r, mLast[d]);
            end else begin
                mValid[d] = 1'b0;
            end
        end
    endtask

    // Compares all outputs of both designs with the model
    task automatic checkAll(input string tag);
        logic [15:0] exp16;
        logic [4:0]  exp5;
        exp16 = mValid[0] ? (16'h1 << mIdx[0]) : 16'h0;
        exp5  = mValid[1] ? (5'h1 << mIdx[1]) : 5'h0;
        checkOutput({tag, ".valid16"},  32'(valid16),  32'(mValid[0]));
        checkOutput({tag, ".onehot16"}, 32'(onehot16), 32'(exp16));
        checkOutput({tag, ".idx16"},    32'(idx16),    mValid[0] ? 32'(mIdx[0]) : 32'h0);
        checkOutput({tag, ".busy16"},   32'(busy16),   32'(mValid[0]));
        checkOutput({tag, ".valid5"},   32'(valid5),   32'(mValid[1]));
        checkOutput({tag, ".onehot5"},  32'(onehot5),  32'(exp5));
        checkOutput({tag, ".idx5"},     32'(idx5),     mValid[1] ? 32'(mIdx[1]) : 32'h0);
        checkOutput({tag, ".idx5_range"}, 32'(idx5 < 3'd5), 32'h1);
    endtask

    // Drives one cycle of inputs away from the edge, then checks after the edge
    task automatic applyStimulus(input string tag, input logic [15:0] r16, input logic rdy16,
                                 input logic [4:0] r5, input logic rdy5);
        req16   = r16;
        ready16 = rdy16;
        req5    = r5;
        ready5  = rdy5;
        modelStep(0, r16, rdy16);
        modelStep(1, {11'h0, r5}, rdy5);
        @(posedge clk);
        #1;
        checkAll(tag);
    endtask

    // Synchronous-style reset pulse covering one active edge
    task automatic doReset();
        rst     = 1'b1;
        req16   = '0;
        req5    = '0;
        ready16 = 1'b0;
        ready5  = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
        checkAll("reset");
        rst = 1'b0;
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        failCount  = 0;
        mN[0] = 16;
        mN[1] = 5;
        rst     = 1'b1;
        req16   = '0;
        req5    = '0;
        ready16 = 1'b0;
        ready5  = 1'b0;
        modelReset();
        #2;
        checkAll("async_reset");
        @(posedge clk);
        #1;
        doReset();

        // Single requester: grant in the next cycle, then idle after acceptance
        applyStimulus("single", 16'h0001, 1'b1, 5'b00001, 1'b1);
        checkOutput("single.idx0", 32'(idx16), 32'h0);
        applyStimulus("single_drop", 16'h0000, 1'b1, 5'b00000, 1'b1);
        applyStimulus("single_idle", 16'h0000, 1'b1, 5'b00000, 1'b1);

        // All requesting with ready high: 0..15 and 0..4 with no bubbles
        doReset();
        for (int i = 0; i < 18; i++) begin
            applyStimulus("all_req", 16'hFFFF, 1'b1, 5'b11111, 1'b1);
            checkOutput("all_req.seq16", 32'(idx16), 32'(i % 16));
            checkOutput("all_req.seq5", 32'(idx5), 32'(i % 5));
        end

        // Two end clients alternate, then the last one alone wraps to itself
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus("ends", 16'h8001, 1'b1, 5'b10001, 1'b1);
            checkOutput("ends.seq", 32'(idx16), (i % 2 == 0) ? 32'h0 : 32'hF);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus("sole_last", 16'h8000, 1'b1, 5'b10000, 1'b1);
            checkOutput("sole_last.idx", 32'(idx16), 32'hF);
        end

        // Backpressure: idx 3 held while requests change, then 4 on acceptance
        doReset();
        applyStimulus("bp_grant", 16'h0008, 1'b0, 5'b01000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus("bp_hold", 16'h0010, 1'b0, 5'b10000, 1'b0);
            checkOutput("bp_hold.onehot", 32'(onehot16), 32'h0008);
        end
        applyStimulus("bp_accept", 16'h0010, 1'b1, 5'b10000, 1'b1);
        checkOutput("bp_accept.idx", 32'(idx16), 32'h4);

        // Sticky grant with the request dropped, then reset mid-grant
        doReset();
        applyStimulus("sticky_grant", 16'h0080, 1'b0, 5'b00100, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus("sticky_hold", 16'h0000, 1'b0, 5'b00000, 1'b0);
            checkOutput("sticky_hold.idx", 32'(idx16), 32'h7);
        end
        rst = 1'b1;
        modelReset();
        #2;
        checkAll("mid_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus("post_reset", 16'h00FF, 1'b1, 5'b00110, 1'b1);
        checkOutput("post_reset.idx", 32'(idx16), 32'h0);

        // Randomized requests and backpressure
        doReset();
        for (int i = 0; i < 400; i++) begin
            logic [15:0] r16;
            logic [4:0]  r5;
            r16 = (i % 3 == 0) ? 16'($urandom) : 16'($urandom & $urandom & $urandom);
            r5  = 5'($urandom & $urandom);
            applyStimulus("random", r16, $urandom_range(0, 3) != 0, r5, $urandom_range(0, 3) != 0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/rr_grant_encoder.md
Name: rr_grant_encoder

Overview:
- Parametrised round-robin arbiter over NUM_CLIENTS request lines.
- Emits a registered one-hot grant plus its binary index, under a valid/ready handshake toward the consumer.
- The binary index is built by OR-reducing the one-hot grant against per-bit index masks: bit b of the index is the OR of all grant bits whose position has bit b set.
- Sits between client request lines and a shared resource; the successor to the static mask generator, now sequential, with fairness and backpressure.

Parameters:
- NUM_CLIENTS, 16, number of requesters; any value >= 2, power of two not required.
- IDX_W, derived: max(1, $clog2(NUM_CLIENTS)); width of the binary index. Not user-overridable.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- req  input  NUM_CLIENTS  request vector; bit i = client i requesting
- gnt_valid  output  1  grant presented
- gnt_ready  input  1  consumer accepts grant this cycle
- gnt_onehot  output  NUM_CLIENTS  registered one-hot grant; all-zero when gnt_valid=0
- gnt_idx  output  IDX_W  binary encoding of gnt_onehot; 0 when gnt_valid=0
- busy  output  1  high in GRANT state (equals gnt_valid)

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; gnt_valid=0, gnt_onehot=0, gnt_idx=0, busy=0.
  - Pointer last_idx=NUM_CLIENTS-1, so the first search starts at client 0.
- Arbitration (combinational, every cycle):
  - hi = req with bits 0..last_idx cleared.
  - If hi!=0, winner = lowest set bit of hi; else winner = lowest set bit of req.
  - win_idx is encoded via the mask OR-reduction. No priority-encoder loop on the index path.
- States:
  - IDLE: if |req, register winner into gnt_onehot/gnt_idx, set gnt_valid=1, go to GRANT. Else stay.
  - GRANT: outputs held stable while gnt_ready=0.
    - On gnt_valid&gnt_ready, last_idx<=gnt_idx.
    - In the same cycle, re-arbitrate using pointer=gnt_idx (the just-accepted index), with req sampled that cycle.
    - If a winner exists: load it, stay in GRANT (back-to-back, no bubble). Else clear outputs, go to IDLE.
- Latency: req rising in cycle N -> gnt_valid in cycle N+1. Sustained throughput: 1 grant/cycle with gnt_ready tied high.
- Grant is sticky: a client dropping req while granted does not retract the grant; it is still presented until accepted.
- Fairness: after client k is accepted, every other requesting client is served before k again. Worst-case wait is NUM_CLIENTS-1 grants.
- Wrap-around: if last_idx=NUM_CLIENTS-1, hi is empty and the search restarts at bit 0. If the only requester is the last-granted client, it is granted again.
- Non-power-of-two NUM_CLIENTS: indices >= NUM_CLIENTS never appear; gnt_idx < NUM_CLIENTS always.
- Invariants:
  - gnt_onehot has exactly one bit set iff gnt_valid=1.
  - gnt_onehot[gnt_idx]=1 whenever gnt_valid=1.
  - Outputs are stable while gnt_valid&!gnt_ready.
- Reset mid-grant: outputs drop to 0 asynchronously, pointer returns to NUM_CLIENTS-1, and the pending grant is discarded with no handshake.
- X on req while in IDLE or at handshake is a bench error; RTL does not filter it.

Test Plan:
- Reset then req=16'h0001, gnt_ready=1 -> cycle+1: gnt_valid=1, gnt_onehot=0x0001, gnt_idx=0; then req=0 -> gnt_valid=0 the cycle after acceptance.
- req=16'hFFFF held, gnt_ready=1 -> gnt_idx sequence 0,1,2,...,15,0,1 on consecutive cycles, with no bubbles.
- req=16'h8001, last_idx=15 after reset -> grants 0,15,0,15; then with only req[15] set after grant 15 -> 15 is granted again (wrap, sole requester).
- Granted idx=3, gnt_ready=0 for 5 cycles while req changes to 0x0010 -> gnt_onehot=0x0008 and gnt_idx=3 stable all 5 cycles; on ready, next grant idx=4.
- Grant idx=7 presented, req[7] dropped before ready -> grant stays idx=7 until accepted; rst pulsed mid-grant -> outputs 0 immediately; after release with req=0x00FF, first grant is idx=0.
- NUM_CLIENTS=5, req=5'b11111 -> gnt_idx cycles 0..4 and wraps to 0; IDX_W=3; idx 5..7 never observed.
